// File: rtl/mat_stream_loader_if.sv
// -----------------------------------------------------------------------------
// mat_stream_loader_if
//   Byte-stream handshake carrying matrix operands into mat_stream_loader.
//   A transfer happens on a rising clock edge when in_valid && in_ready.
//
//   Signals
//     in_data   [ELEM_W-1:0]  stream byte               (master -> slave)
//     in_valid                in_data is valid          (master -> slave)
//     in_last                 final byte of a frame     (master -> slave)
//     in_ready                slave accepts this cycle  (slave -> master)
//
//   Modports
//     master : the byte source
//     slave  : the loader
// -----------------------------------------------------------------------------
interface mat_stream_loader_if #(
  parameter int ELEM_W = 8
);
  logic [ELEM_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/mat_stream_loader.sv
// -----------------------------------------------------------------------------
// mat_stream_loader
//   Upstream feeder for the 3x3 matrix-multiply stage. Collects an 18-byte
//   frame (A row-major, then B row-major) from a valid/ready stream, packs it
//   into A_mat/B_mat, then sequences the multiplier: one cycle of mult_rst_n
//   low, RUN_CYCLES cycles of mult_en high, then a bounded wait for
//   mult_valid. Both matrices stay frozen from the end of the frame until the
//   loader is back in LOAD.
//
//   Ports
//     clk         in   rising-edge clock
//     reset_n     in   synchronous, active-low reset
//     flush       in   synchronous abort back to LOAD (matrices kept)
//     s_if        slave modport of mat_stream_loader_if (in_data/in_valid/
//                 in_last in, in_ready out)
//     A_mat       out  [0:71], element e at bits [8*e +: 8] (e = 3*r + c)
//     B_mat       out  same packing as A_mat
//     mult_rst_n  out  multiplier reset, low for one cycle per run
//     mult_en     out  multiplier enable, high RUN_CYCLES cycles per run
//     mult_valid  in   multiplier result valid, only looked at in WAIT
//     done        out  one-cycle pulse, multiplier result valid
//     busy        out  high in CLR/RUN/WAIT
//     err         out  one-cycle pulse on framing error or WAIT timeout
//
//   The interface instance must be built with the same ELEM_W as this module.
// -----------------------------------------------------------------------------
module mat_stream_loader #(
  parameter int ELEM_W     = 8,
  parameter int N_ELEM     = 9,
  parameter int RUN_CYCLES = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  mat_stream_loader_if.slave           s_if,
  output logic [0:ELEM_W*N_ELEM-1]     A_mat,
  output logic [0:ELEM_W*N_ELEM-1]     B_mat,
  output logic                         mult_rst_n,
  output logic                         mult_en,
  input  logic                         mult_valid,
  output logic                         done,
  output logic                         busy,
  output logic                         err
);

  localparam int MAT_W  = ELEM_W * N_ELEM;
  localparam int BEATS  = 2 * N_ELEM;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int BASE_W = $clog2(MAT_W);
  localparam int RC_W   = $clog2(RUN_CYCLES + 1);
  localparam int WC_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLR,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RC_W-1:0]   rc_q;
  logic [WC_W-1:0]   wc_q;
  logic [0:MAT_W-1]  a_mat_q, a_mat_d;
  logic [0:MAT_W-1]  b_mat_q, b_mat_d;
  logic              in_ready_q;
  logic              mult_rst_n_q;
  logic              mult_en_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;

  logic              xfer;
  logic              last_beat;
  logic              is_a;
  logic [IDX_W-1:0]  elem_idx;
  logic [BASE_W-1:0] bit_base;

  // Beat decode and matrix write. in_ready_q is only high in LOAD, so a
  // transfer can never touch the matrices while a run is in progress.
  always_comb begin
    xfer      = s_if.in_valid && in_ready_q;
    last_beat = (cnt_q == CNT_W'(BEATS - 1));
    is_a      = (cnt_q < CNT_W'(N_ELEM));
    elem_idx  = is_a ? IDX_W'(cnt_q) : IDX_W'(cnt_q - CNT_W'(N_ELEM));
    bit_base  = BASE_W'(int'(elem_idx) * ELEM_W);
    a_mat_d   = a_mat_q;
    b_mat_d   = b_mat_q;
    // A byte that arrives together with flush is dropped.
    if (xfer && !flush) begin
      if (is_a) a_mat_d[bit_base +: ELEM_W] = s_if.in_data;
      else      b_mat_d[bit_base +: ELEM_W] = s_if.in_data;
    end
  end

  // Control FSM with registered outputs; every output reflects the state
  // being entered, so e.g. mult_rst_n is low exactly during the CLR cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      rc_q         <= '0;
      wc_q         <= '0;
      a_mat_q      <= '0;
      b_mat_q      <= '0;
      in_ready_q   <= 1'b1;
      mult_rst_n_q <= 1'b1;
      mult_en_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      a_mat_q      <= a_mat_d;
      b_mat_q      <= b_mat_d;
      // Pulse outputs default low; the branches below raise them for one cycle.
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mult_rst_n_q <= 1'b1;

      if (flush) begin
        state_q    <= S_LOAD;
        cnt_q      <= '0;
        rc_q       <= '0;
        wc_q       <= '0;
        in_ready_q <= 1'b1;
        mult_en_q  <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (xfer) begin
              if (s_if.in_last && last_beat) begin
                state_q      <= S_CLR;
                cnt_q        <= '0;
                in_ready_q   <= 1'b0;
                mult_rst_n_q <= 1'b0;
                busy_q       <= 1'b1;
              end else if (s_if.in_last || last_beat) begin
                // Short frame, or a full frame without its end marker.
                err_q <= 1'b1;
                cnt_q <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end

          S_CLR: begin
            state_q   <= S_RUN;
            rc_q      <= '0;
            mult_en_q <= 1'b1;
          end

          S_RUN: begin
            if (rc_q == RC_W'(RUN_CYCLES - 1)) begin
              state_q   <= S_WAIT;
              mult_en_q <= 1'b0;
              wc_q      <= '0;
            end else begin
              rc_q <= rc_q + RC_W'(1);
            end
          end

          S_WAIT: begin
            if (mult_valid) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (wc_q == WC_W'(TIMEOUT - 1)) begin
              state_q    <= S_LOAD;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b1;
              cnt_q      <= '0;
            end else begin
              wc_q <= wc_q + WC_W'(1);
            end
          end

          S_DONE: begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
          end

          default: begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            mult_en_q  <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_if.in_ready = in_ready_q;
  assign A_mat         = a_mat_q;
  assign B_mat         = b_mat_q;
  assign mult_rst_n    = mult_rst_n_q;
  assign mult_en       = mult_en_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mat_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_mat_stream_loader
//   Directed bench for mat_stream_loader. Inputs change 1 time unit after the
//   rising edge; outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_mat_stream_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        mult_valid;
  logic [0:71] A_mat;
  logic [0:71] B_mat;
  logic        mult_rst_n;
  logic        mult_en;
  logic        done;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0] fr [18];

  mat_stream_loader_if #(.ELEM_W(8)) s_if ();

  mat_stream_loader #(
    .ELEM_W(8), .N_ELEM(9), .RUN_CYCLES(3), .TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .s_if       (s_if),
    .A_mat      (A_mat),
    .B_mat      (B_mat),
    .mult_rst_n (mult_rst_n),
    .mult_en    (mult_en),
    .mult_valid (mult_valid),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int a0, input int as, input int b0, input int bs);
    for (int i = 0; i < 9; i++) begin
      fr[i]     = 8'(a0 + i * as);
      fr[9 + i] = 8'(b0 + i * bs);
    end
  endtask

  // Offers nbytes of fr[], in_last on beat last_at (-1 for none); with
  // bubbles set, in_valid alternates 1/0. Returns one cycle after the last
  // accepted byte.
  task automatic stream(input int nbytes, input int last_at, input bit bubbles);
    int k = 0;
    int guard = 0;
    bit ph = 1'b0;
    bit acc;
    while (k < nbytes && guard < 200) begin
      if (bubbles && ph) begin
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
      end else begin
        s_if.in_valid = 1'b1;
        s_if.in_data  = fr[k];
        s_if.in_last  = (k == last_at);
      end
      acc = s_if.in_valid && s_if.in_ready;
      tick();
      if (acc) k++;
      ph = ~ph;
      guard++;
    end
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
    checks++;
    if (k !== nbytes) begin
      errors++;
      $display("FAIL stream_accept: accepted %0d bytes, required %0d", k, nbytes);
    end
  endtask

  // Entered in the CLR cycle right after the last byte; walks the run,
  // raises mult_valid after `delay` WAIT cycles and checks the done pulse.
  task automatic run_mult(input string tag, input int delay);
    checks++;
    if (mult_rst_n !== 1'b0) begin errors++; $display("FAIL %s clr_rst_n: got %b required 0", tag, mult_rst_n); end
    checks++;
    if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL %s clr_ready: got %b required 0", tag, s_if.in_ready); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s clr_busy: got %b required 1", tag, busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mult_en !== 1'b1) begin errors++; $display("FAIL %s run_en[%0d]: got %b required 1", tag, i, mult_en); end
      checks++;
      if (mult_rst_n !== 1'b1) begin errors++; $display("FAIL %s run_rst_n[%0d]: got %b required 1", tag, i, mult_rst_n); end
      checks++;
      if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL %s run_ready[%0d]: got %b required 0", tag, i, s_if.in_ready); end
    end
    tick();
    checks++;
    if (mult_en !== 1'b0) begin errors++; $display("FAIL %s wait_en: got %b required 0", tag, mult_en); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s wait_busy: got %b required 1", tag, busy); end
    for (int i = 0; i < delay; i++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL %s early_done[%0d]: got %b required 0", tag, i, done); end
    end
    mult_valid = 1'b1;
    tick();
    mult_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b required 1", tag, done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s done_busy: got %b required 0", tag, busy); end
    checks++;
    if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL %s done_ready: got %b required 0", tag, s_if.in_ready); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL %s done_err: got %b required 0", tag, err); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b required 0", tag, done); end
    checks++;
    if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL %s load_ready: got %b required 1", tag, s_if.in_ready); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", s_if.in_ready); end
    checks++;
    if (mult_rst_n !== 1'b1) begin errors++; $display("FAIL reset_rst_n: got %b required 1", mult_rst_n); end
    checks++;
    if (mult_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b required 0", mult_en); end
    checks++;
    if ({done, busy, err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b required 000", {done, busy, err}); end
    checks++;
    if (A_mat !== 72'h0) begin errors++; $display("FAIL reset_A: got %h required 0", A_mat); end
    checks++;
    if (B_mat !== 72'h0) begin errors++; $display("FAIL reset_B: got %h required 0", B_mat); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", s_if.in_ready); end
  endtask

  task automatic test_basic();
    fill(1, 1, 0, 0);
    fr[9]  = 8'h01;
    fr[13] = 8'h01;
    fr[17] = 8'h01;
    stream(18, 17, 1'b0);
    run_mult("basic", 0);
    checks++;
    if (A_mat !== 72'h010203040506070809) begin errors++; $display("FAIL basic_A: got %h required 010203040506070809", A_mat); end
    checks++;
    if (B_mat !== 72'h010000000100000001) begin errors++; $display("FAIL basic_B: got %h required 010000000100000001", B_mat); end
  endtask

  task automatic test_bubbles();
    fill('h10, 'h10, 'hA1, 1);
    stream(18, 17, 1'b1);
    // Keep offering a byte with in_last during the run; it must be ignored.
    s_if.in_valid = 1'b1;
    s_if.in_data  = 8'hEE;
    s_if.in_last  = 1'b1;
    run_mult("bubbles", 2);
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
    checks++;
    if (A_mat !== 72'h102030405060708090) begin errors++; $display("FAIL bubbles_A: got %h required 102030405060708090", A_mat); end
    checks++;
    if (B_mat !== 72'hA1A2A3A4A5A6A7A8A9) begin errors++; $display("FAIL bubbles_B: got %h required a1a2a3a4a5a6a7a8a9", B_mat); end
  endtask

  task automatic test_framing();
    fill('h77, 0, 'h77, 0);
    stream(5, 4, 1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL short_err: got %b required 1", err); end
    checks++;
    if (busy !== 1'b0 || s_if.in_ready !== 1'b1) begin errors++; $display("FAIL short_state: got busy=%b ready=%b required busy=0 ready=1", busy, s_if.in_ready); end
    tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL short_err_width: got %b required 0", err); end
    // A full 18 bytes without the end marker is also a framing error.
    stream(18, -1, 1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL nolast_err: got %b required 1", err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nolast_busy: got %b required 0", busy); end
    fill(9, -1, 'h21, 1);
    stream(18, 17, 1'b0);
    run_mult("framing_recover", 1);
    checks++;
    if (A_mat !== 72'h090807060504030201) begin errors++; $display("FAIL recover_A: got %h required 090807060504030201", A_mat); end
    checks++;
    if (B_mat !== 72'h212223242526272829) begin errors++; $display("FAIL recover_B: got %h required 212223242526272829", B_mat); end
  endtask

  task automatic test_timeout();
    int n;
    fill('h02, 0, 'h03, 0);
    // mult_valid is high through LOAD/CLR/RUN, where it must be ignored.
    mult_valid = 1'b1;
    stream(18, 17, 1'b0);
    tick();
    tick();
    tick();
    mult_valid = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL timeout_early_done: got %b required 0", done); end
    checks++;
    if (busy !== 1'b1 || mult_en !== 1'b0) begin errors++; $display("FAIL timeout_wait: got busy=%b en=%b required busy=1 en=0", busy, mult_en); end
    n = 0;
    while (err !== 1'b1 && n < 30) begin
      if (done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL timeout_done: got %b required 0 at wait cycle %0d", done, n);
      end
      tick();
      n++;
    end
    checks++;
    if (n !== 15) begin errors++; $display("FAIL timeout_cycles: got %0d required 15", n); end
    checks++;
    if (busy !== 1'b0 || s_if.in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: got busy=%b ready=%b done=%b required 0 1 0", busy, s_if.in_ready, done);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_width: got %b required 0", err); end
  endtask

  task automatic test_flush();
    fill('h31, 1, 'h41, 1);
    stream(18, 17, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (mult_en !== 1'b0) begin errors++; $display("FAIL flush_en: got %b required 0", mult_en); end
    checks++;
    if (busy !== 1'b0 || s_if.in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got busy=%b ready=%b required 0 1", busy, s_if.in_ready); end
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || mult_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL flush_pulses: got done=%b err=%b rst_n=%b required 0 0 1", done, err, mult_rst_n);
    end
    checks++;
    if (A_mat !== 72'h313233343536373839) begin errors++; $display("FAIL flush_A_kept: got %h required 313233343536373839", A_mat); end
    // mult_valid in LOAD must not produce done.
    mult_valid = 1'b1;
    tick();
    mult_valid = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL flush_no_done: got done=%b err=%b required 0 0", done, err); end
    // Byte presented together with flush is dropped.
    s_if.in_valid = 1'b1;
    s_if.in_data  = 8'h55;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    s_if.in_valid = 1'b0;
    checks++;
    if (A_mat !== 72'h313233343536373839) begin errors++; $display("FAIL flush_drop: got %h required 313233343536373839", A_mat); end
    // Reset in the middle of a run.
    stream(18, 17, 1'b0);
    tick();
    checks++;
    if (mult_en !== 1'b1) begin errors++; $display("FAIL midrun_en: got %b required 1", mult_en); end
    reset_n = 1'b0;
    tick();
    checks++;
    if ({s_if.in_ready, mult_rst_n, mult_en, done, busy, err} !== 6'b110000) begin
      errors++;
      $display("FAIL midrun_reset_ctrl: got %b required 110000", {s_if.in_ready, mult_rst_n, mult_en, done, busy, err});
    end
    checks++;
    if (A_mat !== 72'h0 || B_mat !== 72'h0) begin errors++; $display("FAIL midrun_reset_mat: got A=%h B=%h required 0 0", A_mat, B_mat); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    fill('h51, 1, 'h61, 1);
    stream(18, 17, 1'b0);
    tick();
    tick();
    tick();
    tick();
    mult_valid = 1'b1;
    tick();
    mult_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b required 1", done); end
    checks++;
    if (A_mat !== 72'h515253545556575859 || B_mat !== 72'h616263646566676869) begin
      errors++;
      $display("FAIL b2b_frame1: got A=%h B=%h required 515253545556575859 616263646566676869", A_mat, B_mat);
    end
    // Offer frame 2 byte 0 during DONE.
    fill('h71, 1, 'h81, 1);
    s_if.in_valid = 1'b1;
    s_if.in_data  = fr[0];
    s_if.in_last  = 1'b0;
    checks++;
    if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready: got %b required 0", s_if.in_ready); end
    tick();
    checks++;
    if (A_mat !== 72'h515253545556575859) begin errors++; $display("FAIL b2b_not_taken: got %h required 515253545556575859", A_mat); end
    stream(18, 17, 1'b0);
    run_mult("b2b_run2", 0);
    checks++;
    if (A_mat !== 72'h717273747576777879) begin errors++; $display("FAIL b2b_A2: got %h required 717273747576777879", A_mat); end
    checks++;
    if (B_mat !== 72'h818283848586878889) begin errors++; $display("FAIL b2b_B2: got %h required 818283848586878889", B_mat); end
  endtask

  initial begin
    reset_n       = 1'b0;
    flush         = 1'b0;
    mult_valid    = 1'b0;
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
    s_if.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_bubbles();
    test_framing();
    test_timeout();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
